rotor_stack: RTL and testbench
==============================

# rotor_stack

Three-rotor scrambler with stepping for the Enigma datapath. Accepts one plaintext letter per transaction and advances the rotors with the historical double-step rule. It passes the letter right→left through the rotors, out to the UKW-B reflector stage through a combinational port pair, and back left→right. The plugboard stage sits upstream; the reflector stage hangs off `refl_char_o`/`refl_char_i`.

## Interface
Parameters:
- `ROTOR_L` — 0 — left rotor type index: 0=I, 1=II, 2=III.
- `ROTOR_M` — 1 — middle rotor type index.
- `ROTOR_R` — 2 — right rotor type index.

Ports:
- `clk` — in — 1 — single clock, all state on rising edge.
- `rst_n` — in — 1 — synchronous, active-low reset.
- `cfg_load` — in — 1 — load start positions and rings; honoured in IDLE only.
- `cfg_pos_l`, `cfg_pos_m`, `cfg_pos_r` — in — 5 each — start positions, 0..25.
- `cfg_ring_l`, `cfg_ring_m`, `cfg_ring_r` — in — 5 each — ring settings, 0..25.
- `in_valid` — in — 1 — input letter valid.
- `in_ready` — out — 1 — block can accept a letter.
- `in_char` — in — 5 — letter, 0=A..25=Z.
- `out_valid` — out — 1 — result valid.
- `out_ready` — in — 1 — downstream accepts the result.
- `out_char` — out — 5 — enciphered letter.
- `out_bypass` — out — 1 — input was ≥26 and was passed through unchanged.
- `refl_char_o` — out — 5 — letter to the reflector.
- `refl_char_i` — in — 5 — reflector result, combinational from `refl_char_o`.
- `pos_l`, `pos_m`, `pos_r` — out — 5 each — current rotor positions.

## Operation
- FSM states: IDLE → STEP → F_R → F_M → F_L → REFL → B_L → B_M → B_R → OUT → IDLE.
- IDLE:
  - `in_ready = !cfg_load`.
  - `cfg_load` has priority over `in_valid`. It loads positions and rings, and a letter is not accepted in that cycle.
  - `cfg_load` in any other state is ignored.
- Accept (`in_valid && in_ready`): register `in_char` and go to STEP.
  - If `in_char ≥ 26`, go directly to OUT with `out_char = in_char`, `out_bypass = 1`, and no stepping.
- STEP: all three positions update in one cycle from pre-step values.
  - `r_notch = (pos_r == NOTCH[ROTOR_R])`.
  - `m_notch = (pos_m == NOTCH[ROTOR_M])`.
  - The right rotor always steps.
  - The middle rotor steps if `r_notch || m_notch` (double step).
  - The left rotor steps if `m_notch`.
  - Each step is +1 mod 26, with 25 wrapping to 0.
- Forward through rotor k (one per F state):
  - `s = (c + pos_k − ring_k) mod 26`.
  - `c' = (WIRING[k][s] − pos_k + ring_k) mod 26`.
- Backward through rotor k (B states): same formula using `INV_WIRING`.
- Arithmetic for the mod-26 offsets:
  - Use 6-bit intermediates.
  - Reduce with a single conditional add or subtract of 26. No `%` operator.
- REFL: `refl_char_o` is driven from the working register, and `refl_char_i` is captured at the end of the cycle.
  - Outside REFL, `refl_char_o` holds the working register value and must not be relied on.
- OUT: `out_valid = 1`. `out_char` and `out_bypass` are held stable until `out_ready`. Then go to IDLE.
- Reset values:
  - state IDLE.
  - positions 0, rings 0.
  - working register 0.
  - `out_valid` 0, `out_char` 0, `out_bypass` 0.
  - `in_ready` is 1 in the first cycle after reset release.
- Reset asserted mid-transaction aborts it:
  - No output is produced.
  - Any position stepping already applied is discarded, because positions reset to 0.

## Timing
- Accept at cycle T → STEP at T+1, F_R at T+2 … B_R at T+8.
- `out_valid` is high from T+9. Latency is 9 cycles.
- Bypass path: `out_valid` is high from T+1.
- `pos_*` show post-step values from T+2 onward.
- OUT handshake at cycle U → IDLE with `in_ready` high at U+1.
- Sustained throughput is one letter per 10 cycles when `out_ready` is held at 1.
- `out_ready` held low keeps the block in OUT indefinitely, with all outputs stable.

## Structure
- Package `enigma_pkg`:
  - `letter_t` (5-bit).
  - `WIRING[3][26]` and `INV_WIRING[3][26]` for rotors I/II/III.
  - `NOTCH[3]` = {16 (Q), 4 (E), 21 (V)}.
  - Function `add26`.
  - FSM state enum.
- One sub-module, `rotor_map`: combinational, taking letter, position, ring, type and direction and returning the mapped letter. It is instantiated once and time-shared across the six F/B states.

## Test plan
- Rotors I-II-III, rings AAA, positions AAA; key AAAAA → BDZGO. Final positions A A F.
- Double step: positions ADU, three keypresses → positions ADV, AEW, BFX after each press respectively.
- Rings BBB, positions AAA; key AAAAA → EWTYX.
- Reciprocity: reload AAA and encipher BDZGO → AAAAA. For every letter, `out_char != in_char`.
- Backpressure and config gating:
  - Hold `out_ready = 0` for 20 cycles; `out_char` is stable and `in_ready = 0`.
  - `cfg_load` pulsed during F_M leaves positions unchanged.
- Bypass and reset:
  - `in_char = 27` → `out_char = 27`, `out_bypass = 1`, `out_valid` at T+1, positions unchanged.
  - `rst_n` low during B_M → `out_valid` stays 0, positions 0, `in_ready = 1` in the cycle after release.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types, rotor tables and mod-26 helpers for the Enigma datapath.
// Rotor index 0/1/2 selects rotor I/II/III in every table.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  typedef enum logic [3:0] {
    S_IDLE, S_STEP, S_F_R, S_F_M, S_F_L, S_REFL, S_B_L, S_B_M, S_B_R, S_OUT
  } state_t;

  localparam letter_t WIRING [3][26] = '{
    '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
      5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9},
    '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
      5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4},
    '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
      5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14}
  };

  localparam letter_t INV_WIRING [3][26] = '{
    '{5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
      5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9},
    '{5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
      5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18},
    '{5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
      5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12}
  };

  // Turnover positions: Q, E, V.
  localparam letter_t NOTCH [3] = '{5'd16, 5'd4, 5'd21};

  // a in 0..25, b in 0..26: one conditional subtract is enough.
  function automatic letter_t add26(letter_t a, letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic letter_t neg26(letter_t b);
    return (b == 5'd0) ? 5'd0 : 5'd26 - b;
  endfunction

endpackage

// File: rtl/rotor_map.sv
// Combinational single-rotor substitution, forward (dir=0) or inverse (dir=1),
// compensated for rotor position and ring setting.
module rotor_map
  import enigma_pkg::*;
(
  input  logic [4:0] ch,
  input  logic [4:0] pos,
  input  logic [4:0] ring,
  input  logic [1:0] rtype,
  input  logic       dir,
  output logic [4:0] mapped
);

  logic [4:0] contact;
  logic [4:0] wired;

  always_comb begin
    contact = add26(add26(ch, pos), neg26(ring));
    wired   = dir ? INV_WIRING[rtype][contact] : WIRING[rtype][contact];
    mapped  = add26(add26(wired, neg26(pos)), ring);
  end

endmodule

// File: rtl/rotor_stack.sv
// Three-rotor Enigma scrambler: double-step stepping, then one rotor per cycle
// out to an external reflector and back, through a single shared rotor_map.
module rotor_stack
  import enigma_pkg::*;
#(
  parameter int ROTOR_L = 0,
  parameter int ROTOR_M = 1,
  parameter int ROTOR_R = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_load,
  input  logic [4:0] cfg_pos_l,
  input  logic [4:0] cfg_pos_m,
  input  logic [4:0] cfg_pos_r,
  input  logic [4:0] cfg_ring_l,
  input  logic [4:0] cfg_ring_m,
  input  logic [4:0] cfg_ring_r,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_char,
  output logic       out_bypass,
  output logic [4:0] refl_char_o,
  input  logic [4:0] refl_char_i,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r
);

  localparam logic [1:0] TYPE_L = 2'(ROTOR_L);
  localparam logic [1:0] TYPE_M = 2'(ROTOR_M);
  localparam logic [1:0] TYPE_R = 2'(ROTOR_R);

  state_t     state, state_nxt;
  logic [4:0] ring_l, ring_m, ring_r;
  logic [4:0] work;
  logic [4:0] map_pos, map_ring, map_out;
  logic [1:0] map_type;
  logic       map_dir;
  logic       accept, bypass_in, r_notch, m_notch;

  // Valid/ready: a transfer happens on a rising edge where both are high.
  // in_ready only in IDLE without cfg_load; out_valid holds in OUT, and
  // out_char/out_bypass stay stable, until out_ready completes the transfer.
  assign accept      = in_valid && in_ready;
  assign bypass_in   = (in_char >= 5'd26);
  assign r_notch     = (pos_r == NOTCH[ROTOR_R]);
  assign m_notch     = (pos_m == NOTCH[ROTOR_M]);
  assign refl_char_o = work;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = bypass_in ? S_OUT : S_STEP;
      S_STEP: state_nxt = S_F_R;
      S_F_R:  state_nxt = S_F_M;
      S_F_M:  state_nxt = S_F_L;
      S_F_L:  state_nxt = S_REFL;
      S_REFL: state_nxt = S_B_L;
      S_B_L:  state_nxt = S_B_M;
      S_B_M:  state_nxt = S_B_R;
      S_B_R:  state_nxt = S_OUT;
      S_OUT:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) && !cfg_load;
    out_valid = (state == S_OUT);
    map_dir   = (state == S_B_L) || (state == S_B_M) || (state == S_B_R);
    map_pos   = pos_l;
    map_ring  = ring_l;
    map_type  = TYPE_L;
    case (state)
      S_F_R, S_B_R: begin
        map_pos  = pos_r;
        map_ring = ring_r;
        map_type = TYPE_R;
      end
      S_F_M, S_B_M: begin
        map_pos  = pos_m;
        map_ring = ring_m;
        map_type = TYPE_M;
      end
      default: ;
    endcase
  end

  rotor_map u_map (
    .ch     (work),
    .pos    (map_pos),
    .ring   (map_ring),
    .rtype  (map_type),
    .dir    (map_dir),
    .mapped (map_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_l      <= 5'd0;
      pos_m      <= 5'd0;
      pos_r      <= 5'd0;
      ring_l     <= 5'd0;
      ring_m     <= 5'd0;
      ring_r     <= 5'd0;
      work       <= 5'd0;
      out_char   <= 5'd0;
      out_bypass <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            pos_l  <= cfg_pos_l;
            pos_m  <= cfg_pos_m;
            pos_r  <= cfg_pos_r;
            ring_l <= cfg_ring_l;
            ring_m <= cfg_ring_m;
            ring_r <= cfg_ring_r;
          end else if (accept) begin
            work <= in_char;
            if (bypass_in) begin
              out_char   <= in_char;
              out_bypass <= 1'b1;
            end
          end
        end
        // All three rotors step together from their pre-step positions.
        S_STEP: begin
          pos_r <= add26(pos_r, 5'd1);
          if (r_notch || m_notch) pos_m <= add26(pos_m, 5'd1);
          if (m_notch) pos_l <= add26(pos_l, 5'd1);
        end
        S_F_R, S_F_M, S_F_L, S_B_L, S_B_M: work <= map_out;
        S_REFL: work <= refl_char_i;
        S_B_R: begin
          work       <= map_out;
          out_char   <= map_out;
          out_bypass <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rotor_stack.sv
// Directed bench for rotor_stack with rotors I-II-III and a UKW-B reflector
// model closing the refl_char_o/refl_char_i loop.
module tb_rotor_stack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_load;
  logic [4:0] cfg_pos_l, cfg_pos_m, cfg_pos_r;
  logic [4:0] cfg_ring_l, cfg_ring_m, cfg_ring_r;
  logic       in_valid, in_ready;
  logic [4:0] in_char;
  logic       out_valid, out_ready;
  logic [4:0] out_char;
  logic       out_bypass;
  logic [4:0] refl_char_o, refl_char_i;
  logic [4:0] pos_l, pos_m, pos_r;

  int checks = 0;
  int errors = 0;

  // UKW-B: YRUHQSLDPXNGOKMIEBFZCWVJAT
  logic [4:0] ukw [26] = '{5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15,
                           5'd23, 5'd13, 5'd6, 5'd14, 5'd10, 5'd12, 5'd8, 5'd4, 5'd1,
                           5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

  assign refl_char_i = (refl_char_o < 5'd26) ? ukw[refl_char_o] : 5'd0;

  always #5 clk = ~clk;

  rotor_stack #(.ROTOR_L(0), .ROTOR_M(1), .ROTOR_R(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_pos_l   (cfg_pos_l),
    .cfg_pos_m   (cfg_pos_m),
    .cfg_pos_r   (cfg_pos_r),
    .cfg_ring_l  (cfg_ring_l),
    .cfg_ring_m  (cfg_ring_m),
    .cfg_ring_r  (cfg_ring_r),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_char    (out_char),
    .out_bypass  (out_bypass),
    .refl_char_o (refl_char_o),
    .refl_char_i (refl_char_i),
    .pos_l       (pos_l),
    .pos_m       (pos_m),
    .pos_r       (pos_r)
  );

  task automatic do_cfg(input int pl, input int pm, input int pr,
                        input int rl, input int rm, input int rr);
    @(negedge clk);
    cfg_load   = 1'b1;
    cfg_pos_l  = pl[4:0];
    cfg_pos_m  = pm[4:0];
    cfg_pos_r  = pr[4:0];
    cfg_ring_l = rl[4:0];
    cfg_ring_m = rm[4:0];
    cfg_ring_r = rr[4:0];
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // One letter through the block. lat counts cycles from the accept edge to
  // the first cycle with out_valid. A nonzero cfg_at pulses cfg_load (with
  // junk values) in that cycle of the transaction.
  task automatic run_txn(input logic [4:0] c, input int cfg_at,
                         output logic [4:0] o, output logic byp, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = c;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
      cfg_load = (n == cfg_at);
      if (cfg_load) begin
        cfg_pos_l = 5'd9; cfg_pos_m = 5'd9; cfg_pos_r = 5'd9;
        cfg_ring_l = 5'd9; cfg_ring_m = 5'd9; cfg_ring_r = 5'd9;
      end
    end
    cfg_load = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL txn_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
    end
    lat = n;
    o   = out_char;
    byp = out_bypass;
    if (out_ready) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_after_out: got %b required 1", in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_char !== 5'd0 || out_bypass !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_char=%0d out_bypass=%b required 1 0 0 0",
               in_ready, out_valid, out_char, out_bypass);
    end
    checks++;
    if (pos_l !== 5'd0 || pos_m !== 5'd0 || pos_r !== 5'd0) begin
      errors++;
      $display("FAIL reset_pos: got %0d %0d %0d required 0 0 0", pos_l, pos_m, pos_r);
    end
  endtask

  task automatic test_basic();
    logic [4:0] exp_c [5];
    logic [4:0] o;
    logic       b;
    int         lat;
    exp_c = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};  // BDZGO
    do_cfg(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      run_txn(5'd0, 0, o, b, lat);
      checks++;
      if (o !== exp_c[i]) begin
        errors++;
        $display("FAIL basic[%0d]: got %0d required %0d", i, o, exp_c[i]);
      end
      checks++;
      if (o === 5'd0) begin
        errors++;
        $display("FAIL basic_selfmap[%0d]: got %0d required not 0", i, o);
      end
      checks++;
      if (lat != 9 || b !== 1'b0) begin
        errors++;
        $display("FAIL basic_latency[%0d]: latency %0d bypass %b required 9 0", i, lat, b);
      end
    end
    checks++;
    if (pos_l !== 5'd0 || pos_m !== 5'd0 || pos_r !== 5'd5) begin
      errors++;
      $display("FAIL basic_pos: got %0d %0d %0d required 0 0 5", pos_l, pos_m, pos_r);
    end
  endtask

  task automatic test_double_step();
    logic [4:0] exp_l [3];
    logic [4:0] exp_m [3];
    logic [4:0] exp_r [3];
    logic [4:0] o;
    logic       b;
    int         lat;
    exp_l = '{5'd0, 5'd0, 5'd1};
    exp_m = '{5'd3, 5'd4, 5'd5};
    exp_r = '{5'd21, 5'd22, 5'd23};
    do_cfg(0, 3, 20, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_txn(5'd0, 0, o, b, lat);
      checks++;
      if (pos_l !== exp_l[i] || pos_m !== exp_m[i] || pos_r !== exp_r[i]) begin
        errors++;
        $display("FAIL double_step[%0d]: got %0d %0d %0d required %0d %0d %0d",
                 i, pos_l, pos_m, pos_r, exp_l[i], exp_m[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_rings();
    logic [4:0] exp_c [5];
    logic [4:0] o;
    logic       b;
    int         lat;
    exp_c = '{5'd4, 5'd22, 5'd19, 5'd24, 5'd23};  // EWTYX
    do_cfg(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      run_txn(5'd0, 0, o, b, lat);
      checks++;
      if (o !== exp_c[i]) begin
        errors++;
        $display("FAIL rings[%0d]: got %0d required %0d", i, o, exp_c[i]);
      end
    end
  endtask

  task automatic test_reciprocity();
    logic [4:0] in_c [5];
    logic [4:0] o;
    logic       b;
    int         lat;
    in_c = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};  // BDZGO
    do_cfg(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      run_txn(in_c[i], 0, o, b, lat);
      checks++;
      if (o !== 5'd0) begin
        errors++;
        $display("FAIL reciprocity[%0d]: got %0d required 0", i, o);
      end
      checks++;
      if (o === in_c[i]) begin
        errors++;
        $display("FAIL recip_selfmap[%0d]: got %0d required not %0d", i, o, in_c[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] o;
    logic       b;
    int         lat;
    do_cfg(0, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    run_txn(5'd0, 0, o, b, lat);
    checks++;
    if (o !== 5'd1) begin
      errors++;
      $display("FAIL bp_value: got %0d required 1", o);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_char !== 5'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_char=%0d out_valid=%b in_ready=%b required 1 1 0",
                 i, out_char, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_cfg_gating();
    logic [4:0] o;
    logic       b;
    int         lat;
    do_cfg(0, 0, 0, 0, 0, 0);
    run_txn(5'd0, 3, o, b, lat);
    checks++;
    if (pos_l !== 5'd0 || pos_m !== 5'd0 || pos_r !== 5'd1) begin
      errors++;
      $display("FAIL cfg_gating_pos: got %0d %0d %0d required 0 0 1", pos_l, pos_m, pos_r);
    end
    checks++;
    if (o !== 5'd1) begin
      errors++;
      $display("FAIL cfg_gating_value: got %0d required 1", o);
    end
  endtask

  task automatic test_bypass();
    logic [4:0] o;
    logic       b;
    int         lat;
    do_cfg(2, 3, 4, 0, 0, 0);
    run_txn(5'd27, 0, o, b, lat);
    checks++;
    if (o !== 5'd27 || b !== 1'b1) begin
      errors++;
      $display("FAIL bypass_value: got %0d bypass %b required 27 1", o, b);
    end
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL bypass_latency: got %0d required 1", lat);
    end
    checks++;
    if (pos_l !== 5'd2 || pos_m !== 5'd3 || pos_r !== 5'd4) begin
      errors++;
      $display("FAIL bypass_pos: got %0d %0d %0d required 2 3 4", pos_l, pos_m, pos_r);
    end
    run_txn(5'd0, 0, o, b, lat);
    checks++;
    if (b !== 1'b0 || pos_r !== 5'd5) begin
      errors++;
      $display("FAIL bypass_clear: bypass %b pos_r %0d required 0 5", b, pos_r);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_cfg(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);  // now mid B_M
    checks++;
    if (pos_r !== 5'd1) begin
      errors++;
      $display("FAIL reset_mid_prestep: pos_r %0d required 1", pos_r);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || pos_l !== 5'd0 || pos_m !== 5'd0 || pos_r !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_state: out_valid=%b pos %0d %0d %0d required 0 0 0 0",
               out_valid, pos_l, pos_m, pos_r);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b required 1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_output: out_valid rose after abort, required 0");
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_load   = 1'b0;
    cfg_pos_l  = 5'd0; cfg_pos_m = 5'd0; cfg_pos_r = 5'd0;
    cfg_ring_l = 5'd0; cfg_ring_m = 5'd0; cfg_ring_r = 5'd0;
    in_valid   = 1'b0;
    in_char    = 5'd0;
    out_ready  = 1'b1;
    test_reset();
    test_basic();
    test_double_step();
    test_rings();
    test_reciprocity();
    test_backpressure();
    test_cfg_gating();
    test_bypass();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
